// File: rtl/mac_sequencer.sv
// Sequencer that runs one MAC_Core through a len-term dot product.
// Optional build macro MAC_SEQ_RELU_EN clamps negative results to zero on capture.
module mac_sequencer #(
   parameter int N     = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     result,
   output logic [LEN_W-1:0] mem_addr,
   output logic             mem_rd,
   input  logic [N-1:0]     mem_weight,
   input  logic [N-1:0]     mem_in,
   output logic [N-1:0]     mac_weight,
   output logic [N-1:0]     mac_in,
   output logic             mac_clear,
   output logic             mac_forget,
   output logic             mac_oe,
   input  logic [N-1:0]     mac_out
);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE} state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic             drain_cnt;
   // [0]: memory data valid this cycle, [1]: MAC operand registers valid
   logic [1:0]       vld_pipe;
   logic [N-1:0]     captured;

`ifdef MAC_SEQ_RELU_EN
   assign captured = mac_out[N-1] ? '0 : mac_out;
`else
   assign captured = mac_out;
`endif

   assign mac_forget = ~vld_pipe[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         len_q      <= '0;
         drain_cnt  <= 1'b0;
         vld_pipe   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         mac_weight <= '0;
         mac_in     <= '0;
         mac_clear  <= 1'b0;
         mac_oe     <= 1'b0;
      end else begin
         done     <= 1'b0;
         vld_pipe <= {vld_pipe[0], mem_rd};
         if (vld_pipe[0]) begin
            mac_weight <= mem_weight;
            mac_in     <= mem_in;
         end
         if (abort && state != IDLE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mac_clear <= 1'b0;
            mac_oe    <= 1'b0;
            vld_pipe  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        state     <= CLEAR;
                        len_q     <= len;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                     end else begin
                        result <= '0;
                        done   <= 1'b1;
                     end
                  end
               end
               CLEAR: begin
                  state     <= STREAM;
                  mac_clear <= 1'b0;
                  mem_rd    <= 1'b1;
                  mem_addr  <= '0;
               end
               STREAM: begin
                  // address holds at the last term once the read stream ends
                  if (mem_addr == len_q - LEN_W'(1)) begin
                     state     <= DRAIN;
                     mem_rd    <= 1'b0;
                     drain_cnt <= 1'b0;
                  end else begin
                     mem_addr <= mem_addr + LEN_W'(1);
                  end
               end
               DRAIN: begin
                  if (drain_cnt) begin
                     state  <= CAPTURE;
                     mac_oe <= 1'b1;
                  end else begin
                     drain_cnt <= 1'b1;
                  end
               end
               CAPTURE: begin
                  state  <= IDLE;
                  mac_oe <= 1'b0;
                  busy   <= 1'b0;
                  result <= captured;
                  done   <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural sync memory and MAC_Core.
module tb_mac_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] len = '0;
   logic       busy, done, mem_rd, mac_clear, mac_forget, mac_oe;
   logic [7:0] result, mem_addr, mac_weight, mac_in, mac_out;
   logic [7:0] mem_weight = '0;
   logic [7:0] mem_in = '0;
   logic [7:0] wmem [0:7];
   logic [7:0] imem [0:7];
   logic [7:0] acc = '0;
   int total = 0;
   int bad = 0;

   mac_sequencer #(.N(8), .LEN_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
      .busy(busy), .done(done), .result(result), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_weight(mem_weight), .mem_in(mem_in), .mac_weight(mac_weight), .mac_in(mac_in),
      .mac_clear(mac_clear), .mac_forget(mac_forget), .mac_oe(mac_oe), .mac_out(mac_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_weight <= wmem[mem_addr[2:0]];
         mem_in     <= imem[mem_addr[2:0]];
      end
   end

   always @(posedge clk) begin
      if (mac_clear) acc <= '0;
      else if (!mac_forget) acc <= acc + mac_weight * mac_in;
   end
   assign mac_out = mac_oe ? acc : '0;

   task automatic load_mem(input logic [7:0] w, input logic [7:0] i);
      for (int k = 0; k < 8; k++) begin
         wmem[k] = w;
         imem[k] = i;
      end
   endtask

   // drive start in cycle 0; the following posedge samples it
   task automatic launch(input logic [7:0] l);
      @(negedge clk);
      start = 1'b1;
      len   = l;
   endtask

   task automatic test_reset;
      logic [31:0] got;
      #12;
      got = {busy, done, result, mem_addr, mem_rd, mac_weight[6:0], mac_clear, mac_forget, mac_oe};
      total++;
      if (got !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=%h", got,
                  {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0});
      end
      total++;
      if (mac_in !== 8'h00) begin
         bad++;
         $display("FAIL reset_mac_in got=%h exp=00", mac_in);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] fmask = '0, cmask = '0, rmask = '0;
      logic [23:0] addrs = '0;
      logic [7:0]  res = '0;
      logic        busy1 = 1'b0, busy_d = 1'b1;
      int          dc = -1;
      load_mem(8'h02, 8'h02);
      launch(8'd3);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin start = 1'b0; busy1 = busy; end
         if (!mac_forget) fmask[c] = 1'b1;
         if (mac_clear) cmask[c] = 1'b1;
         if (mem_rd) rmask[c] = 1'b1;
         if (c >= 2 && c <= 4) addrs = {addrs[15:0], mem_addr};
         if (done && dc < 0) begin dc = c; res = result; busy_d = busy; end
      end
      total++;
      if (fmask !== 32'h70) begin bad++; $display("FAIL basic_forget_low got=%h exp=00000070", fmask); end
      total++;
      if (cmask !== 32'h02) begin bad++; $display("FAIL basic_clear got=%h exp=00000002", cmask); end
      total++;
      if (rmask !== 32'h1C) begin bad++; $display("FAIL basic_mem_rd got=%h exp=0000001c", rmask); end
      total++;
      if (addrs !== 24'h000102) begin bad++; $display("FAIL basic_addr_seq got=%h exp=000102", addrs); end
      total++;
      if (dc !== 8) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=8", dc); end
      total++;
      if (res !== 8'h0C) begin bad++; $display("FAIL basic_result got=%h exp=0c", res); end
      total++;
      if (busy1 !== 1'b1 || busy_d !== 1'b0) begin
         bad++; $display("FAIL basic_busy got=%b%b exp=10", busy1, busy_d);
      end
      total++;
      if (mem_addr !== 8'd2) begin bad++; $display("FAIL basic_addr_hold got=%0d exp=2", mem_addr); end
   endtask

   task automatic test_negative;
      logic [7:0] res = '0;
      logic [7:0] exp_res;
      int         dc = -1;
`ifdef MAC_SEQ_RELU_EN
      exp_res = 8'h00;
`else
      exp_res = 8'hFC;
`endif
      load_mem(8'hFE, 8'h02);
      wmem[0] = 8'h02;
      launch(8'd3);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done && dc < 0) begin dc = c; res = result; end
      end
      total++;
      if (dc !== 8) begin bad++; $display("FAIL neg_done_cycle got=%0d exp=8", dc); end
      total++;
      if (res !== exp_res) begin bad++; $display("FAIL neg_result got=%h exp=%h", res, exp_res); end
   endtask

   task automatic test_len0;
      int   dc = -1;
      logic any_act = 1'b0;
      logic [7:0] res = 8'hAA;
      launch(8'd0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (mac_clear || mem_rd || busy || mac_oe) any_act = 1'b1;
         if (done && dc < 0) begin dc = c; res = result; end
      end
      total++;
      if (dc !== 1) begin bad++; $display("FAIL len0_done_cycle got=%0d exp=1", dc); end
      total++;
      if (res !== 8'h00) begin bad++; $display("FAIL len0_result got=%h exp=00", res); end
      total++;
      if (any_act !== 1'b0) begin bad++; $display("FAIL len0_activity got=%b exp=0", any_act); end
   endtask

   task automatic test_start_ignored;
      int         dc = -1, nd = 0;
      logic [7:0] res = '0;
      load_mem(8'h02, 8'h02);
      launch(8'd3);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 3) begin start = 1'b1; len = 8'd1; end
         if (c == 4) start = 1'b0;
         if (done) begin nd++; if (dc < 0) begin dc = c; res = result; end end
      end
      total++;
      if (nd !== 1 || dc !== 8) begin
         bad++; $display("FAIL ignore_start got=%0d@%0d exp=1@8", nd, dc);
      end
      total++;
      if (res !== 8'h0C) begin bad++; $display("FAIL ignore_start_result got=%h exp=0c", res); end
   endtask

   task automatic test_abort;
      int         nd = 0, dc = -1;
      logic [7:0] a3 = '0, res = '0;
      logic [3:0] st = '0;
      load_mem(8'h07, 8'h01);
      launch(8'd5);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 3) begin a3 = mem_addr; abort = 1'b1; end
         if (c == 4) begin st = {busy, mem_rd, mac_forget, mac_oe}; abort = 1'b0; end
         if (done) nd++;
      end
      total++;
      if (a3 !== 8'd1) begin bad++; $display("FAIL abort_term got=%0d exp=1", a3); end
      total++;
      if (st !== 4'b0010) begin bad++; $display("FAIL abort_outputs got=%b exp=0010", st); end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
      total++;
      if (result !== 8'h0C) begin bad++; $display("FAIL abort_result_held got=%h exp=0c", result); end
      load_mem(8'h03, 8'h01);
      launch(8'd2);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done && dc < 0) begin dc = c; res = result; end
      end
      total++;
      if (dc !== 7 || res !== 8'h06) begin
         bad++; $display("FAIL abort_rerun got=%h@%0d exp=06@7", res, dc);
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] got;
      logic [1:0]  pre = '0;
      logic        act = 1'b0;
      load_mem(8'h02, 8'h02);
      launch(8'd4);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      pre = {mem_rd, mac_forget};
      #2 reset = 1'b1;
      #1;
      got = {busy, done, result, mem_addr, mem_rd, mac_weight[6:0], mac_clear, mac_forget, mac_oe};
      total++;
      if (pre !== 2'b10) begin bad++; $display("FAIL async_pre_state got=%b exp=10", pre); end
      total++;
      if (got !== {1'b0, 1'b0, 8'h06, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0} && result !== 8'h00) begin
         bad++; $display("FAIL async_reset_result got=%h exp=00", result);
      end
      total++;
      if (got[23:0] !== {8'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0} || busy !== 1'b0 || done !== 1'b0
          || mac_in !== 8'h00 || result !== 8'h00) begin
         bad++; $display("FAIL async_reset_outputs got=%h exp=00000004", got);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (busy || done || mem_rd) act = 1'b1;
      end
      total++;
      if (act !== 1'b0) begin bad++; $display("FAIL async_reset_idle got=%b exp=0", act); end
   endtask

   task automatic test_back_to_back;
      int         d1 = -1, d2 = -1, nd = 0;
      logic [7:0] r1 = '0, r2 = '0;
      logic       b8 = 1'b0;
      load_mem(8'h03, 8'h01);
      launch(8'd2);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 8) begin b8 = busy; start = 1'b0; end
         if (done) begin
            nd++;
            if (d1 < 0) begin d1 = c; r1 = result; end
            else if (d2 < 0) begin d2 = c; r2 = result; end
         end
      end
      total++;
      if (d1 !== 7 || d2 !== 14 || nd !== 2) begin
         bad++; $display("FAIL b2b_done got=%0d,%0d n=%0d exp=7,14 n=2", d1, d2, nd);
      end
      total++;
      if (r1 !== 8'h06 || r2 !== 8'h06) begin
         bad++; $display("FAIL b2b_result got=%h,%h exp=06,06", r1, r2);
      end
      total++;
      if (b8 !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", b8); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_len0();
      test_start_ignored();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Controller that sequences one MAC_Core through a dot-product of `len` terms. On `start` it clears the MAC accumulator, streams weight/input pairs from an external synchronous memory into the MAC, then enables the MAC output and captures the result. It sits between the layer scheduler (start/done handshake) and a single MAC_Core instance plus its weight/input memories.

## Interface
- `N`, 8: data width of weight, input and MAC output
- `LEN_W`, 8: width of `len` and `mem_addr`

- `clk`  in  1: system clock, rising edge
- `reset`  in  1: asynchronous, active-high reset
- `start`  in  1: start request, sampled only in IDLE
- `abort`  in  1: synchronous abort of a running sequence
- `len`  in  LEN_W: number of terms, latched on accepted `start`
- `busy`  out  1: high from the cycle after accepted `start` until return to IDLE
- `done`  out  1: one-cycle pulse, `result` valid
- `result`  out  N: captured MAC result, held until next capture
- `mem_addr`  out  LEN_W: term index to memories
- `mem_rd`  out  1: read strobe; memory data valid the cycle after
- `mem_weight`  in  N: weight read data
- `mem_in`  in  N: input read data
- `mac_weight`  out  N: registered weight to MAC_Core `weight`
- `mac_in`  out  N: registered input to MAC_Core `in`
- `mac_clear`  out  1: drives MAC_Core `reset` (accumulator clear)
- `mac_forget`  out  1: drives MAC_Core `forget`; high = current product not accumulated
- `mac_oe`  out  1: drives MAC_Core `oe`
- `mac_out`  in  N: MAC_Core `out`

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, CAPTURE.
- IDLE: `start`=1 and `len`≠0 → CLEAR; `start`=1 and `len`=0 → stay IDLE, `result`←0, `done` pulses next cycle, no MAC activity.
- CLEAR (1 cycle): `mac_clear`=1, `mac_forget`=1.
- STREAM (`len` cycles): `mem_rd`=1, `mem_addr` = 0,1,…,`len`-1.
- Data pipeline: memory data registered into `mac_weight`/`mac_in`; `mac_forget` pipelined so it is low exactly in the `len` cycles those registers hold a valid term.
- DRAIN (2 cycles): flushes the pipeline; `mem_rd`=0.
- CAPTURE (1 cycle): `mac_oe`=1, `mac_forget`=1; `mac_out` sampled into `result` at the end of the cycle → IDLE with `done`=1.
- `start` outside IDLE ignored. `start` during the `done` cycle (IDLE) is accepted.
- `abort`=1 in any non-IDLE state → IDLE next cycle; `mem_rd`, `mac_oe` drop to 0, `mac_forget`=1, no `done`, `result` unchanged. Next run re-clears the MAC.
- `len` changes after acceptance have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `mem_addr`=0, `mem_rd`=0, `mac_weight`=0, `mac_in`=0, `mac_clear`=0, `mac_forget`=1, `mac_oe`=0; state IDLE. Reset mid-sequence returns all of these immediately, no `done`.
- Cycle 0 = `start` sampled. CLEAR at 1; STREAM at 2..`len`+1; term k valid at MAC in cycle k+3; DRAIN at `len`+2..`len`+3; CAPTURE at `len`+4; `done` and new `result` at cycle `len`+5.
- Latency `len`+5 cycles; `len`=0 latency 1 cycle.
- `mem_addr` stays at last value outside STREAM; max `len` = 2^LEN_W−1, no wrap.
- `result` is the MAC output bit-for-bit (two's complement, N bits); no width change in the controller.

## Configuration
- `MAC_SEQ_RELU_EN` defined: captured value passes through ReLU; if `mac_out[N-1]`=1, `result`←0, else `result`←`mac_out`. `len`=0 result still 0.
- Undefined: `result`←`mac_out` unmodified.

## Test plan
- `len`=3, weights 2,2,2, inputs 2,2,2 → `result`=12 (0x0C), `done` at cycle 8, `mac_forget` low cycles 4–6, `mac_clear` high cycle 1 only.
- `len`=3, weights 0x02,0xFE,0xFE, inputs 2 → `result`=0xFC without `MAC_SEQ_RELU_EN`, 0x00 with it.
- `len`=0 → `done` at cycle 1, `result`=0, `mac_clear`/`mem_rd` never asserted, `busy` stays 0.
- `start` pulsed during STREAM → ignored; `abort` in STREAM term 1 → `busy`=0 next cycle, no `done`; following `len`=2 run with weights 3,3 inputs 1,1 → `result`=6.
- `reset` asserted asynchronously mid-STREAM → all outputs reach reset values before next clock edge; state IDLE.
- `start` held high through `done` cycle → second run accepted in the `done` cycle, second `done` `len`+5 cycles later.
